// File: rtl/tt_um_carlosgs99_div_4bits_if.sv
// Request/response bundle of the sequential divider: operands in, quotient/remainder/status out.
interface tt_um_carlosgs99_div_4bits_if #(
  parameter int unsigned bits = 4
);
  logic                  start;
  logic [2*bits-1:0]     P;
  logic [bits-1:0]       B;
  logic                  busy;
  logic                  done;
  logic                  dz;
  logic [2*bits-1:0]     Q;
  logic [bits-1:0]       R;

  modport master (
    output start, P, B,
    input  busy, done, dz, Q, R
  );

  modport slave (
    input  start, P, B,
    output busy, done, dz, Q, R
  );
endinterface

// File: rtl/tt_um_carlosgs99_div_4bits.sv
// Sequential restoring divider: 2*bits-wide dividend by bits-wide divisor, one quotient bit per cycle.
// Inverts the companion multiplier, so P = A*B divided by B returns A with zero remainder.
module tt_um_carlosgs99_div_4bits #(
  parameter int unsigned bits = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  tt_um_carlosgs99_div_4bits_if.slave       bus
);

  localparam int unsigned DW = 2 * bits;
  localparam int unsigned RW = bits + 1;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_d;

  logic [DW-1:0]   dvd, dvd_d;
  logic [DW-1:0]   quo, quo_d;
  logic [bits-1:0] dvs, dvs_d;
  logic [bits-1:0] rem, rem_d;
  logic [CW-1:0]   cnt, cnt_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic [DW-1:0]   q_q, q_d;
  logic [bits-1:0] r_q, r_d;

  logic [RW-1:0]   trial;
  logic [RW-1:0]   diff;
  logic            ge;
  logic [bits-1:0] rem_step;
  logic [DW-1:0]   quo_step;
  logic            last;

  // One restoring step. The partial remainder stays below the divisor, so the
  // borrow out of the (bits+1)-wide subtraction is exactly the "trial < divisor" test.
  always_comb begin
    trial    = {rem, dvd[DW-1]};
    diff     = trial - {1'b0, dvs};
    ge       = ~diff[RW-1];
    rem_step = ge ? diff[bits-1:0] : trial[bits-1:0];
    quo_step = {quo[DW-2:0], ge};
    last     = (cnt == CW'(DW - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state;
    dvd_d   = dvd;
    quo_d   = quo;
    dvs_d   = dvs;
    rem_d   = rem;
    cnt_d   = cnt;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.B == '0) begin
            // Divide by zero completes on the accept edge without entering RUN.
            q_d    = '1;
            r_d    = '0;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            dvd_d   = bus.P;
            dvs_d   = bus.B;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        dvd_d = {dvd[DW-2:0], 1'b0};
        cnt_d = cnt + CW'(1);
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          q_d     = quo_step;
          r_d     = rem_step;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dvd    <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
    end else begin
      state  <= state_d;
      dvd    <= dvd_d;
      quo    <= quo_d;
      dvs    <= dvs_d;
      rem    <= rem_d;
      cnt    <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
      q_q    <= q_d;
      r_q    <= r_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;

endmodule

// File: tb/tb_tt_um_carlosgs99_div_4bits.sv
// Scoreboard bench for the 4-bit restoring divider: directed vectors plus multiplier cross-check sweeps.
module tb_tt_um_carlosgs99_div_4bits;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  tt_um_carlosgs99_div_4bits_if #(.bits(4)) bus ();

  tt_um_carlosgs99_div_4bits #(.bits(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 (Q=%0d R=%0d) expected no done", bus.Q, bus.R);
      end else begin
        mon_e = sb.pop_front();
        chk("Q", int'(bus.Q), int'(mon_e.q));
        chk("R", int'(bus.R), int'(mon_e.r));
        chk("dz", int'(bus.dz), int'(mon_e.dz));
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge; start is accepted on the following posedge.
  task automatic issue(input logic [7:0] p, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r, input logic push);
    exp_t e;
    bus.start = 1'b1;
    bus.P     = p;
    bus.B     = b;
    if (push) begin
      e.q   = q;
      e.r   = r;
      e.dz  = (b == 4'd0);
      e.cyc = cyc + ((b == 4'd0) ? 1 : 9);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.P     = 8'($urandom);
    bus.B     = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 30 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected $finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.P     = 8'($urandom);
    bus.B     = 4'($urandom);

    // Reset held with start asserted: nothing may be captured
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_dz", int'(bus.dz), 0);
      chk("rst_Q", int'(bus.Q), 0);
      chk("rst_R", int'(bus.R), 0);
      bus.P = 8'($urandom);
      bus.B = 4'($urandom);
    end
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);

    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b1);
    chk("run_busy", int'(bus.busy), 1);
    drain();
    chk("post_busy", int'(bus.busy), 0);

    // Boundaries
    issue(8'd255, 4'd1,  8'd255, 4'd0,  1'b1); drain();
    issue(8'd225, 4'd15, 8'd15,  4'd0,  1'b1); drain();
    issue(8'd0,   4'd9,  8'd0,   4'd0,  1'b1); drain();
    issue(8'd14,  4'd15, 8'd0,   4'd14, 1'b1); drain();

    // Divide by zero
    issue(8'd13, 4'd0, 8'd255, 4'd0, 1'b1);
    chk("dz_busy0", int'(bus.busy), 0);
    @(negedge clk);
    chk("dz_busy1", int'(bus.busy), 0);
    chk("dz_hold", int'(bus.dz), 1);
    drain();
    issue(8'd13, 4'd5, 8'd2, 4'd3, 1'b1); drain();

    // Start while busy is ignored; outputs hold old result during RUN
    issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.P     = 8'd50;
    bus.B     = 4'd5;
    chk("hold_Q", int'(bus.Q), 2);
    chk("hold_R", int'(bus.R), 3);
    chk("busy_mid", int'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    // Back-to-back: start during the done cycle
    issue(8'd50, 4'd5, 8'd10, 4'd0, 1'b1);
    drain();

    // Abort mid-RUN
    issue(8'd99, 4'd4, 8'd0, 4'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_Q", int'(bus.Q), 0);
    chk("abort_R", int'(bus.R), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", int'(bus.busy), 0);
    issue(8'd99, 4'd4, 8'd24, 4'd3, 1'b1); drain();

    // Inverse of the multiplier: (A*B)/B
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b1);
        drain();
      end
    end

    // Full dividend sweep against a behavioural quotient/remainder
    for (int p = 0; p < 256; p++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(p), 4'(b), 8'(p / b), 4'(p % b), 1'b1);
        drain();
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
